// File: rtl/mem_alu_pkg.sv
// Shared encodings for the register-op-memory command sequencer.
package mem_alu_pkg;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned REG_AW  = 5;
  localparam int unsigned RAM_AW  = 6;
  localparam int unsigned BYTE_AW = 8;
  localparam int unsigned OP_W    = 3;
  localparam int unsigned ST_W    = 3;

  localparam logic [ST_W-1:0] ST_IDLE  = 3'd0;
  localparam logic [ST_W-1:0] ST_FETCH = 3'd1;
  localparam logic [ST_W-1:0] ST_EXEC  = 3'd2;
  localparam logic [ST_W-1:0] ST_WB    = 3'd3;
  localparam logic [ST_W-1:0] ST_DONE  = 3'd4;

  typedef enum logic [ST_W-1:0] {
    S_IDLE  = ST_IDLE,
    S_FETCH = ST_FETCH,
    S_EXEC  = ST_EXEC,
    S_WB    = ST_WB,
    S_DONE  = ST_DONE
  } state_t;

  localparam logic [OP_W-1:0] OP_AND = 3'b000;
  localparam logic [OP_W-1:0] OP_OR  = 3'b001;
  localparam logic [OP_W-1:0] OP_XOR = 3'b010;
  localparam logic [OP_W-1:0] OP_NOR = 3'b011;
  localparam logic [OP_W-1:0] OP_ADD = 3'b100;
  localparam logic [OP_W-1:0] OP_SUB = 3'b101;
  localparam logic [OP_W-1:0] OP_SLT = 3'b110;
  localparam logic [OP_W-1:0] OP_SLL = 3'b111;

  // Byte address to RAM word index; the two low bits only feed the misaligned flag.
  function automatic logic [RAM_AW-1:0] word_index(input logic [BYTE_AW-1:0] addr);
    return addr[BYTE_AW-1:2];
  endfunction

endpackage

// File: rtl/mem_alu_sequencer.sv
// Multi-cycle controller: reads reg A and a RAM word, runs the ALU, writes the
// result back to a register or the same RAM word, one command at a time.
module mem_alu_sequencer
  import mem_alu_pkg::*;
(
  input  logic                clk_m,
  input  logic                Reset,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_dst_mem,
  input  logic [REG_AW-1:0]   cmd_rs,
  input  logic [REG_AW-1:0]   cmd_rd,
  input  logic [BYTE_AW-1:0]  cmd_mem_addr,
  input  logic [OP_W-1:0]     cmd_alu_op,
  output logic [REG_AW-1:0]   R_Addr_A,
  input  logic [DATA_W-1:0]   R_Data_A,
  output logic [REG_AW-1:0]   W_Addr,
  output logic [DATA_W-1:0]   W_Data,
  output logic                Write_Reg,
  output logic [DATA_W-1:0]   AA,
  output logic [DATA_W-1:0]   BB,
  output logic [OP_W-1:0]     ALU_OP,
  input  logic [DATA_W-1:0]   F,
  output logic [RAM_AW-1:0]   addra,
  output logic                wea,
  output logic [DATA_W-1:0]   dina,
  input  logic [DATA_W-1:0]   douta,
  output logic                done,
  output logic [DATA_W-1:0]   result,
  output logic                misaligned
);

  state_t              state_q;
  logic                dst_mem_q;
  logic [REG_AW-1:0]   rs_q;
  logic [REG_AW-1:0]   rd_q;
  logic [RAM_AW-1:0]   word_q;
  logic                mis_cmd_q;
  logic [OP_W-1:0]     op_q;
  logic [DATA_W-1:0]   alu_q;
  logic [DATA_W-1:0]   result_q;
  logic                misaligned_q;
  logic                done_q;
  logic                wreg_q;
  logic                wea_q;
  logic                in_exec;

  // Sequencer FSM with command latch, ALU capture and registered strobes.
  always_ff @(posedge clk_m) begin
    if (Reset) begin
      state_q      <= S_IDLE;
      dst_mem_q    <= 1'b0;
      rs_q         <= '0;
      rd_q         <= '0;
      word_q       <= '0;
      mis_cmd_q    <= 1'b0;
      op_q         <= '0;
      alu_q        <= '0;
      result_q     <= '0;
      misaligned_q <= 1'b0;
      done_q       <= 1'b0;
      wreg_q       <= 1'b0;
      wea_q        <= 1'b0;
    end else begin
      done_q <= 1'b0;
      wreg_q <= 1'b0;
      wea_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (cmd_valid) begin
            dst_mem_q <= cmd_dst_mem;
            rs_q      <= cmd_rs;
            rd_q      <= cmd_rd;
            word_q    <= word_index(cmd_mem_addr);
            mis_cmd_q <= |cmd_mem_addr[1:0];
            op_q      <= cmd_alu_op;
            state_q   <= S_FETCH;
          end
        end
        S_FETCH: state_q <= S_EXEC;
        S_EXEC: begin
          alu_q   <= F;
          wreg_q  <= ~dst_mem_q;
          wea_q   <= dst_mem_q;
          state_q <= S_WB;
        end
        S_WB: begin
          done_q       <= 1'b1;
          result_q     <= alu_q;
          misaligned_q <= mis_cmd_q;
          state_q      <= S_DONE;
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Operands are live only in EXEC so the ALU sees zeros otherwise.
  assign in_exec    = (state_q == S_EXEC);
  assign AA         = in_exec ? R_Data_A : '0;
  assign BB         = in_exec ? douta    : '0;
  assign ALU_OP     = in_exec ? op_q     : '0;

  assign cmd_ready  = (state_q == S_IDLE);
  assign R_Addr_A   = rs_q;
  assign addra      = word_q;
  assign W_Addr     = rd_q;
  assign W_Data     = alu_q;
  assign dina       = alu_q;
  assign Write_Reg  = wreg_q;
  assign wea        = wea_q;
  assign done       = done_q;
  assign result     = result_q;
  assign misaligned = misaligned_q;

endmodule
